// File: rtl/gem_rx_pkg.sv
// Shared types and helpers for the GEM external-FIFO RX sink.
// Holds the receive FSM state encoding, the status word type and the
// saturating counter increment used by the frame counters.
package gem_rx_pkg;

  localparam int GEM_STATUS_W = 45;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  typedef logic [GEM_STATUS_W-1:0] rx_status_t;

  // Increment by one when en is set, holding at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/gem_rx_status_fifo.sv
// Purpose: per-frame status queue, DEPTH x W, pushed on frame commit.
// Latency: a pushed word is visible on vld_o/dat_o the cycle after the push.
// Backpressure: pops on vld_o & rdy_i; full_o tells the writer to refuse new frames.
module gem_rx_status_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 45
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  output logic         full_o,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  input  logic         rdy_i
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_q, rd_q;
  ptr_t         used;
  logic         pop, push_ok;

  assign used    = wr_q - rd_q;
  assign full_o  = (used == DEPTH_P);
  assign vld_o   = (wr_q != rd_q);
  assign pop     = vld_o && rdy_i;
  assign push_ok = push_i && !full_o;
  // Output forced to zero while empty so reset presents a clean bus.
  assign dat_o   = vld_o ? mem[rd_q[AW-1:0]] : '0;

  // Pointer update: independent push and pop ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by vld_o.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/gem_rx_receiver.sv
// Purpose: GEM RX external-FIFO sink; buffers MAC bytes, commits clean frames, rolls back bad ones.
// Latency: good eop in cycle N gives first tvalid of that frame at N+2; 1 byte/cycle sustained.
// Backpressure: tvalid/tdata hold until tready; a full data or status FIFO drops the frame (rx_w_overflow).
module gem_rx_receiver
  import gem_rx_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int STAT_DEPTH = 4,
  parameter int STATUS_W   = GEM_STATUS_W
) (
  input  logic                rx_clock,
  input  logic                rx_resetn,
  input  logic                rx_w_wr,
  input  logic [7:0]          rx_w_data,
  input  logic                rx_w_sop,
  input  logic                rx_w_eop,
  input  logic [STATUS_W-1:0] rx_w_status,
  input  logic                rx_w_err,
  input  logic                rx_w_flush,
  output logic                rx_w_overflow,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [STATUS_W-1:0] stat_tdata,
  output logic                stat_tvalid,
  input  logic                stat_tready,
  output logic [31:0]         frames_ok,
  output logic [31:0]         frames_dropped
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // Data FIFO: entry is {last, data}
  logic [8:0] mem [DEPTH];

  rx_state_e   state_q, state_d;
  ptr_t        wr_tent_q, wr_tent_d;
  ptr_t        wr_commit_q, wr_commit_d;
  ptr_t        rd_q;
  logic [31:0] ok_q, ok_d;
  logic [31:0] drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic        tvalid_q, tlast_q;
  logic [7:0]  tdata_q;

  logic        mem_we;
  ptr_t        mem_waddr;
  logic [8:0]  mem_wdat;
  logic        stat_push, stat_full;
  logic        start, store;
  ptr_t        base;
  logic        drop_a, drop_b, ok_inc;
  logic        rd_load;

  // Write-side FSM: decides store / commit / rollback for the current MAC write.
  // base is where the byte lands: wr_tent normally, wr_commit when a new sop
  // abandons a partial frame in the same cycle. drop_a counts an abandoned
  // frame, drop_b the current frame, so a restart that also overflows counts two.
  always_comb begin
    state_d     = state_q;
    wr_tent_d   = wr_tent_q;
    wr_commit_d = wr_commit_q;
    ovf_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_tent_q;
    mem_wdat    = {rx_w_eop, rx_w_data};
    stat_push   = 1'b0;
    start       = 1'b0;
    store       = 1'b0;
    base        = wr_tent_q;
    drop_a      = 1'b0;
    drop_b      = 1'b0;
    ok_inc      = 1'b0;

    if (rx_w_flush) begin
      if (state_q == RECV) begin
        wr_tent_d = wr_commit_q;
        drop_a    = 1'b1;
      end
      state_d = IDLE;
    end else if (rx_w_wr) begin
      unique case (state_q)
        IDLE: begin
          if (rx_w_sop) start = 1'b1;
        end
        RECV: begin
          if (rx_w_sop) begin
            drop_a    = 1'b1;
            start     = 1'b1;
            base      = wr_commit_q;
            wr_tent_d = wr_commit_q;
          end else begin
            store = 1'b1;
          end
        end
        DROP: begin
          if (rx_w_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (start || store) begin
        if (((base - rd_q) == DEPTH_P) || (start && stat_full)) begin
          ovf_d     = 1'b1;
          drop_b    = 1'b1;
          wr_tent_d = wr_commit_q;
          state_d   = rx_w_eop ? IDLE : DROP;
        end else if (rx_w_eop && rx_w_err) begin
          drop_b    = 1'b1;
          wr_tent_d = wr_commit_q;
          state_d   = IDLE;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = base;
          wr_tent_d = base + 1'b1;
          if (rx_w_eop) begin
            wr_commit_d = base + 1'b1;
            stat_push   = 1'b1;
            ok_inc      = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
    end

    ok_d   = sat_inc32(ok_q, ok_inc);
    drop_d = sat_inc32(sat_inc32(drop_q, drop_a), drop_b);
  end

  // Write-side state registers.
  always_ff @(posedge rx_clock or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state_q     <= IDLE;
      wr_tent_q   <= '0;
      wr_commit_q <= '0;
      ok_q        <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_tent_q   <= wr_tent_d;
      wr_commit_q <= wr_commit_d;
      ok_q        <= ok_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  // Data FIFO write port; only the uncommitted region is ever written.
  always_ff @(posedge rx_clock) begin
    if (mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdat;
  end

  // Refill the output stage from committed data whenever it is empty or being taken.
  assign rd_load = (rd_q != wr_commit_q) && (!tvalid_q || m_axis_tready);

  // Read pointer and registered output stage.
  always_ff @(posedge rx_clock or negedge rx_resetn) begin
    if (!rx_resetn) begin
      rd_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (rd_load) begin
      {tlast_q, tdata_q} <= mem[rd_q[AW-1:0]];
      tvalid_q           <= 1'b1;
      rd_q               <= rd_q + 1'b1;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  gem_rx_status_fifo #(
    .DEPTH (STAT_DEPTH),
    .W     (STATUS_W)
  ) u_stat_fifo (
    .clk        (rx_clock),
    .rst_n      (rx_resetn),
    .push_i     (stat_push),
    .push_dat_i (rx_w_status),
    .full_o     (stat_full),
    .vld_o      (stat_tvalid),
    .dat_o      (stat_tdata),
    .rdy_i      (stat_tready)
  );

  assign rx_w_overflow  = ovf_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_gem_rx_receiver.sv
// Directed and randomised checks of the GEM RX sink against a byte/status scoreboard.
// DUT built with a 64-byte data FIFO so that capacity edges are reachable quickly.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_gem_rx_receiver;

  localparam int DEPTH = 64;
  localparam int SD    = 4;
  localparam int SW    = 45;

  logic          rx_clock, rx_resetn;
  logic          rx_w_wr, rx_w_sop, rx_w_eop, rx_w_err, rx_w_flush;
  logic [7:0]    rx_w_data;
  logic [SW-1:0] rx_w_status;
  logic          rx_w_overflow;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [SW-1:0] stat_tdata;
  logic          stat_tvalid, stat_tready;
  logic [31:0]   frames_ok, frames_dropped;

  gem_rx_receiver #(.DEPTH(DEPTH), .STAT_DEPTH(SD), .STATUS_W(SW)) dut (
    .rx_clock(rx_clock), .rx_resetn(rx_resetn),
    .rx_w_wr(rx_w_wr), .rx_w_data(rx_w_data), .rx_w_sop(rx_w_sop), .rx_w_eop(rx_w_eop),
    .rx_w_status(rx_w_status), .rx_w_err(rx_w_err), .rx_w_flush(rx_w_flush),
    .rx_w_overflow(rx_w_overflow),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .stat_tdata(stat_tdata), .stat_tvalid(stat_tvalid), .stat_tready(stat_tready),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  initial begin
    rx_clock = 1'b0;
    forever #5 rx_clock = ~rx_clock;
  end

  int          checks = 0, failures = 0;
  logic [8:0]  exp_q[$];
  logic [SW-1:0] exp_s[$];
  longint      beats = 0, stats_seen = 0, committed_bytes = 0, good_frames = 0;
  int          extra = 0, ovf_cnt = 0;
  int          exp_ok = 0, exp_drop = 0;
  bit          rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output scoreboard and overflow pulse counter.
  always @(negedge rx_clock) begin
    if (rx_resetn === 1'b1) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) extra++;
        else chk("beat", {55'd0, m_axis_tlast, m_axis_tdata}, {55'd0, exp_q.pop_front()});
        beats++;
      end
      if (stat_tvalid && stat_tready) begin
        if (exp_s.size() == 0) extra++;
        else chk("status", 64'(stat_tdata), 64'(exp_s.pop_front()));
        stats_seen++;
      end
      if (rx_w_overflow) ovf_cnt++;
    end
  end

  // Random ready generator for the soak phase.
  initial begin
    forever begin
      @(posedge rx_clock);
      #1;
      if (rdy_rand) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        stat_tready   = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic wr_byte(input logic [7:0] d, input logic sop, input logic eop,
                         input logic err, input logic [SW-1:0] st);
    rx_w_wr = 1'b1; rx_w_data = d; rx_w_sop = sop; rx_w_eop = eop;
    rx_w_err = err; rx_w_status = st;
    @(posedge rx_clock);
    #1;
    rx_w_wr = 1'b0; rx_w_sop = 1'b0; rx_w_eop = 1'b0; rx_w_err = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] b0, input logic err,
                            input logic [SW-1:0] st, input bit good, input bit has_eop);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = b0 + 8'(i);
      wr_byte(d, (i == 0), has_eop && (i == len - 1), err && (i == len - 1), st);
    end
    if (good) begin
      for (int i = 0; i < len; i++) begin
        d = b0 + 8'(i);
        exp_q.push_back({(i == len - 1), d});
      end
      exp_s.push_back(st);
      committed_bytes += len;
      good_frames++;
    end
  endtask

  task automatic wait_bytes(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge rx_clock); #1; n++;
    end
    repeat (3) begin @(posedge rx_clock); #1; end
    chk("drain_bytes", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_stats(input int lim);
    int n = 0;
    while (exp_s.size() != 0 && n < lim) begin
      @(posedge rx_clock); #1; n++;
    end
    chk("drain_stats", 64'(exp_s.size()), 64'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_ok"},   64'(frames_ok),      64'(exp_ok));
    chk({tag, "_drop"}, 64'(frames_dropped), 64'(exp_drop));
  endtask

  initial begin
    int ovf0, n, len;
    logic err;
    logic [SW-1:0] st;

    rx_resetn = 1'b0; rx_w_wr = 1'b0; rx_w_data = '0; rx_w_sop = 1'b0; rx_w_eop = 1'b0;
    rx_w_err = 1'b0; rx_w_flush = 1'b0; rx_w_status = '0;
    m_axis_tready = 1'b1; stat_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge rx_clock);
    @(negedge rx_clock);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_svalid", 64'(stat_tvalid),   64'd0);
    chk("rst_ovf",    64'(rx_w_overflow), 64'd0);
    chk_counts("rst");
    @(posedge rx_clock); #1;
    rx_resetn = 1'b1;
    repeat (2) begin @(posedge rx_clock); #1; end

    // T1: 64-byte frame fills the FIFO exactly, status 0x1234
    send_frame(64, 8'h00, 1'b0, 45'h1234, 1'b1, 1'b1);
    exp_ok++;
    wait_bytes(500); wait_stats(50);
    chk("t1_beats", 64'(beats), 64'd64);
    chk_counts("t1");

    // Latency: 1-byte frame, first tvalid two cycles after the eop cycle
    send_frame(1, 8'h77, 1'b0, 45'h1_0000_0077, 1'b1, 1'b1);
    exp_ok++;
    @(negedge rx_clock);
    chk("lat_n1", 64'(m_axis_tvalid), 64'd0);
    @(negedge rx_clock);
    chk("lat_n2", 64'(m_axis_tvalid), 64'd1);
    wait_bytes(50); wait_stats(50);

    // T2: errored 20-byte frame, then good 4-byte frame
    send_frame(20, 8'h20, 1'b1, 45'h0bad, 1'b0, 1'b1);
    exp_drop++;
    send_frame(4, 8'hE0, 1'b0, 45'h55, 1'b1, 1'b1);
    exp_ok++;
    wait_bytes(100); wait_stats(50);
    chk_counts("t2");

    // T3: no drain, 68-byte frame overflows on byte 65
    m_axis_tready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 68; i++) begin
      wr_byte(8'(i), (i == 0), (i == 67), 1'b0, 45'h3);
      if (i == 63) chk("t3_no_ovf_64", 64'(rx_w_overflow), 64'd0);
      if (i == 64) chk("t3_ovf_65",    64'(rx_w_overflow), 64'd1);
    end
    exp_drop++;
    repeat (4) begin @(posedge rx_clock); #1; end
    chk("t3_ovf_once", 64'(ovf_cnt - ovf0), 64'd1);
    chk("t3_no_out",   64'(m_axis_tvalid), 64'd0);
    chk_counts("t3");
    m_axis_tready = 1'b1;
    send_frame(8, 8'h80, 1'b0, 45'h88, 1'b1, 1'b1);
    exp_ok++;
    wait_bytes(100); wait_stats(50);
    chk_counts("t3b");

    // T4: status FIFO full, fifth single-byte frame dropped at sop
    stat_tready = 1'b0;
    ovf0 = ovf_cnt;
    for (int f = 0; f < 4; f++) begin
      send_frame(1, 8'h40 + 8'(f), 1'b0, 45'h400 + 45'(f), 1'b1, 1'b1);
      exp_ok++;
    end
    send_frame(1, 8'h4F, 1'b0, 45'h4FF, 1'b0, 1'b1);
    chk("t4_ovf_sop", 64'(rx_w_overflow), 64'd1);
    exp_drop++;
    wait_bytes(100);
    chk("t4_ovf_once",  64'(ovf_cnt - ovf0), 64'd1);
    chk("t4_stat_held", 64'(stat_tvalid),    64'd1);
    chk("t4_stat_left", 64'(exp_s.size()),   64'd4);
    chk_counts("t4");
    stat_tready = 1'b1;
    wait_stats(50);

    // T5a: sop arrives mid-frame, partial frame rolled back
    send_frame(10, 8'h50, 1'b0, 45'h0, 1'b0, 1'b0);
    send_frame(6, 8'h60, 1'b0, 45'h66, 1'b1, 1'b1);
    exp_drop++; exp_ok++;
    wait_bytes(100); wait_stats(50);
    chk_counts("t5a");

    // T5b: flush mid-frame keeps committed data, ignores writes while high
    m_axis_tready = 1'b0;
    send_frame(3, 8'hA0, 1'b0, 45'hA3, 1'b1, 1'b1);
    exp_ok++;
    send_frame(5, 8'hB0, 1'b0, 45'h0, 1'b0, 1'b0);
    rx_w_flush = 1'b1;
    wr_byte(8'hC0, 1'b1, 1'b1, 1'b0, 45'hC0);
    wr_byte(8'hC1, 1'b1, 1'b1, 1'b0, 45'hC1);
    rx_w_flush = 1'b0;
    exp_drop++;
    wr_byte(8'hD0, 1'b0, 1'b0, 1'b0, 45'h0);
    wr_byte(8'hD1, 1'b0, 1'b1, 1'b0, 45'h0);
    m_axis_tready = 1'b1;
    wait_bytes(100); wait_stats(50);
    chk_counts("t5b");
    send_frame(2, 8'hF0, 1'b0, 45'hF2, 1'b1, 1'b1);
    exp_ok++;
    wait_bytes(100); wait_stats(50);
    chk_counts("t5c");

    // T6: random back-to-back frames, random ready on both outputs
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, DEPTH);
      err = ($urandom_range(0, 7) == 0);
      st  = {13'($urandom), 32'($urandom)};
      n = 0;
      while (((committed_bytes - beats + longint'(len)) > DEPTH ||
              (good_frames - stats_seen) >= SD) && n < 2000) begin
        @(posedge rx_clock); #1; n++;
      end
      send_frame(len, 8'($urandom), err, st, !err, 1'b1);
      if (err) exp_drop++; else exp_ok++;
    end
    rdy_rand = 1'b0;
    @(posedge rx_clock); #1;
    m_axis_tready = 1'b1; stat_tready = 1'b1;
    wait_bytes(3000); wait_stats(100);
    chk_counts("t6");

    // Reset during a frame: everything cleared, nothing counted
    send_frame(5, 8'h90, 1'b0, 45'h0, 1'b0, 1'b0);
    #2 rx_resetn = 1'b0;
    @(negedge rx_clock);
    exp_ok = 0; exp_drop = 0;
    chk("rstmid_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_counts("rstmid");
    @(posedge rx_clock); #1;
    rx_resetn = 1'b1;
    @(posedge rx_clock); #1;
    send_frame(2, 8'h31, 1'b0, 45'h31, 1'b1, 1'b1);
    exp_ok++;
    wait_bytes(100); wait_stats(50);
    chk_counts("post_rst");

    chk("extra_out", 64'(extra), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
